multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V style control unit: Moore FSM plus ALU/immediate decode
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       EQ,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUctrl,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ResultSrc / ALUSrcA / ALUSrcB / ImmSrc encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_cur;
  state_t     w_next;
  logic [2:0] w_alu_fn;
  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_done;
  logic       w_illegal;

  // While reset is held the outputs must look like FETCH, even before the
  // first reset edge has loaded the state register.
  assign w_cur = rst_n ? r_state : S_FETCH;

  // State register; synchronous reset returns to FETCH from any state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // ALU operation for R/I-type execute; only R-type may select subtract
  always_comb begin
    w_alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_fn = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_fn = ALU_SLT;
      3'b110:  w_alu_fn = ALU_OR;
      3'b111:  w_alu_fn = ALU_AND;
      default: w_alu_fn = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // Next-state and per-state output decode
  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    AdrSrc     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUctrl    = ALU_ADD;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (w_cur)
      S_FETCH: begin
        w_next    = S_DECODE;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        // OldPC + imm is computed here so BRANCH/JAL find the target in ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
            w_done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_next = S_MEMWB;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        w_next     = S_FETCH;
        ResultSrc  = RES_RDATA;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWRITE: begin
        w_next     = S_FETCH;
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_EXECR: begin
        w_next  = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUctrl = w_alu_fn;
      end
      S_EXECI: begin
        w_next  = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUctrl = w_alu_fn;
      end
      S_ALUWB: begin
        w_next     = S_FETCH;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs1 - rs2; only beq/bne are taken, other funct3 fall through
        w_next    = S_FETCH;
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUctrl   = ALU_SUB;
        w_pcwrite = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);
        w_done    = 1'b1;
      end
      S_JAL: begin
        // PC <- ALUOut (target from DECODE) while OldPC + 4 becomes the link value
        w_next    = S_ALUWB;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        w_pcwrite = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Write enables and pulses are suppressed while reset is held
  always_comb begin
    PCWrite    = w_pcwrite  & rst_n;
    MemWrite   = w_memwrite & rst_n;
    IRWrite    = w_irwrite  & rst_n;
    RegWrite   = w_regwrite & rst_n;
    instr_done = w_done     & rst_n;
    illegal    = w_illegal  & rst_n;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       EQ;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUctrl;
  logic       instr_done, illegal;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] exp_vec;
  bit          exp_valid = 1'b0;
  string       exp_tag;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .EQ(EQ),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .instr_done(instr_done), .illegal(illegal)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUctrl,instr_done,illegal}
  wire [17:0] w_dut = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, instr_done, illegal};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int n_cycles(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == SW || o == RT || o == IT || o == JL) return 4;
    if (o == BR) return 3;
    return 2;
  endfunction

  // Expected outputs for cycle k (0 = fetch) of an instruction
  function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic eq, input int k);
    logic       pcw, adr, mw, irw, rw, done, ill;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, fn;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (f3)
      3'b000:  fn = (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  fn = 3'b101;
      3'b110:  fn = 3'b011;
      3'b111:  fn = 3'b010;
      default: fn = 3'b000;
    endcase
    if (k == 0) begin
      irw = 1; pcw = 1; rs = 2'b10; sb = 2'b10;
    end else if (k == 1) begin
      sa = 2'b01; sb = 2'b01;
      if (n_cycles(o) == 2) begin ill = 1; done = 1; end
    end else if (k == n_cycles(o) - 1 && o != BR && o != SW && o != LW) begin
      rw = 1; done = 1;                         // ALU/link writeback
    end else begin
      case (o)
        LW: if (k == 2) begin sa = 2'b10; sb = 2'b01; end
            else if (k == 3) adr = 1;
            else begin rs = 2'b01; rw = 1; done = 1; end
        SW: if (k == 2) begin sa = 2'b10; sb = 2'b01; end
            else begin adr = 1; mw = 1; done = 1; end
        RT: begin sa = 2'b10; sb = 2'b00; alu = fn; end
        IT: begin sa = 2'b10; sb = 2'b01; alu = fn; end
        BR: begin sa = 2'b10; alu = 3'b001; done = 1;
                  pcw = (f3 == 3'b000 && eq) || (f3 == 3'b001 && !eq); end
        JL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm_of(o), alu, done, ill};
  endfunction

  function automatic logic [17:0] reset_vec(input logic [6:0] o);
    return {5'b00000, 2'b10, 2'b00, 2'b10, imm_of(o), 3'b000, 2'b00};
  endfunction

  // Single compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_valid) begin
      n_cmp++;
      if (w_dut !== exp_vec) begin
        n_bad++;
        $display("FAIL %s: dut=%b expected=%b", exp_tag, w_dut, exp_vec);
      end
    end
  end

  task automatic pin(input string name, input logic [17:0] got, input logic [17:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL pin_%s: model=%b expected=%b", name, got, want);
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic eq, input int limit);
    int n;
    n = n_cycles(o);
    if (limit > 0 && limit < n) n = limit;
    for (int k = 0; k < n; k++) begin
      op = o; funct3 = f3; funct7b5 = f7; EQ = eq;
      exp_vec   = model(o, f3, f7, eq, k);
      exp_tag   = $sformatf("%s_c%0d", name, k + 1);
      exp_valid = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Hand-computed anchors for the model
    pin("fetch_lw",   model(LW, 3'b000, 1'b0, 1'b0, 0), 18'b1_0_0_1_0_10_00_10_00_000_0_0);
    pin("lw_wb",      model(LW, 3'b010, 1'b0, 1'b0, 4), 18'b0_0_0_0_1_01_00_00_00_000_1_0);
    pin("sw_write",   model(SW, 3'b010, 1'b0, 1'b0, 3), 18'b0_1_1_0_0_00_00_00_01_000_1_0);
    pin("sub_exec",   model(RT, 3'b000, 1'b1, 1'b0, 2), 18'b0_0_0_0_0_00_10_00_00_001_0_0);
    pin("beq_taken",  model(BR, 3'b000, 1'b0, 1'b1, 2), 18'b1_0_0_0_0_00_10_00_10_001_1_0);
    pin("jal_state",  model(JL, 3'b000, 1'b0, 1'b0, 2), 18'b1_0_0_0_0_00_01_10_11_000_0_0);
    pin("ill_decode", model(BAD, 3'b000, 1'b0, 1'b0, 1), 18'b0_0_0_0_0_00_01_01_00_000_1_1);
    pin("reset_lw",   reset_vec(LW),                     18'b0_0_0_0_0_10_00_10_00_000_0_0);

    rst_n = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; EQ = 1'b0;
    @(posedge clk); #1;
    exp_vec = reset_vec(LW); exp_tag = "reset"; exp_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;

    run_instr("lw",      LW, 3'b010, 1'b0, 1'b1, 0);
    run_instr("sw",      SW, 3'b010, 1'b1, 1'b0, 0);
    run_instr("add",     RT, 3'b000, 1'b0, 1'b0, 0);
    run_instr("sub",     RT, 3'b000, 1'b1, 1'b1, 0);
    run_instr("slt",     RT, 3'b010, 1'b0, 1'b0, 0);
    run_instr("or",      RT, 3'b110, 1'b0, 1'b0, 0);
    run_instr("addi_f7", IT, 3'b000, 1'b1, 1'b0, 0);
    run_instr("andi",    IT, 3'b111, 1'b0, 1'b0, 0);
    run_instr("beq_t",   BR, 3'b000, 1'b0, 1'b1, 0);
    run_instr("beq_nt",  BR, 3'b000, 1'b0, 1'b0, 0);
    run_instr("bne_t",   BR, 3'b001, 1'b0, 1'b0, 0);
    run_instr("bne_nt",  BR, 3'b001, 1'b0, 1'b1, 0);
    run_instr("blt_x",   BR, 3'b100, 1'b0, 1'b1, 0);
    run_instr("jal",     JL, 3'b000, 1'b0, 1'b1, 0);
    run_instr("illegal", BAD, 3'b000, 1'b0, 1'b0, 0);
    run_instr("lw2",     LW, 3'b010, 1'b0, 1'b0, 0);

    // Reset asserted while in MEMREAD of a load
    run_instr("lw_part", LW, 3'b010, 1'b0, 1'b0, 3);
    rst_n = 1'b0;
    exp_vec = reset_vec(LW); exp_tag = "rst_memread";
    @(posedge clk); #1;
    exp_tag = "rst_hold";
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr("lw_after", LW, 3'b010, 1'b0, 1'b0, 0);
    run_instr("sw_after", SW, 3'b000, 1'b0, 1'b0, 0);

    exp_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
